// File: rtl/sram_like_slave_if.sv
// Address/response handshake between a fetch-stage master and the sram-like responder.
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_slave.sv
// In-order sram-like responder over a 1-cycle sync RAM; SRAM_LIKE_RAND_DELAY_EN adds LFSR stalls.
// Accept at T, data_ok at T+2 earliest; addr_ok drops once DEPTH transactions are outstanding.
module sram_like_slave #(
  parameter int          ADDR_W    = 16,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] LFSR_SEED = 16'h5a5a
) (
  input  logic               clk,
  input  logic               resetn,
  sram_like_slave_if.slave   bus,
  output logic               ram_en,
  output logic [3:0]         ram_wen,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW:0]  cnt_q, cnt_d;
  logic         pipe_vld_q, pipe_wr_q;
  logic [PW:0]  wptr_q, rptr_q;
  logic [31:0]  fifo_q [DEPTH];
  logic         fifo_empty;
  logic         blk_a, blk_d;
  logic         accept, respond;
  logic [3:0]   mask;
  logic         unused_ok;

`ifdef SRAM_LIKE_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign blk_a = (lfsr_q[1:0] == 2'b00);
  assign blk_d = (lfsr_q[3:2] == 2'b00);
`else
  assign blk_a = 1'b0;
  assign blk_d = 1'b0;
`endif

  assign unused_ok = ^{LFSR_SEED, bus.addr[31:ADDR_W+2]};

  // resetn gates the combinational accept so every output is 0 while reset is held
  assign fifo_empty = (wptr_q == rptr_q);
  assign accept     = resetn && bus.req && (cnt_q != FULL) && !blk_a;
  assign respond    = !fifo_empty && !blk_d;

  assign bus.addr_ok = accept;
  assign bus.data_ok = respond;
  assign bus.rdata   = respond ? fifo_q[rptr_q[PW-1:0]] : 32'h0;

  always_comb begin
    mask = 4'b1111;
    case (bus.size)
      2'd0:    mask = 4'b0001 << bus.addr[1:0];
      2'd1:    mask = 4'b0011 << {bus.addr[1], 1'b0};
      default: mask = 4'b1111;
    endcase
  end

  assign ram_en    = accept;
  assign ram_wen   = (accept && bus.wr) ? mask : 4'b0000;
  assign ram_addr  = accept ? bus.addr[ADDR_W+1:2] : '0;
  assign ram_wdata = accept ? bus.wdata : 32'h0;

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, respond})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      pipe_vld_q <= 1'b0;
      pipe_wr_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      pipe_vld_q <= accept;
      pipe_wr_q  <= bus.wr;
      if (pipe_vld_q) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (respond) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // count gating guarantees a slot exists whenever stage 1 pushes
  always_ff @(posedge clk) begin
    if (pipe_vld_q) begin
      fifo_q[wptr_q[PW-1:0]] <= pipe_wr_q ? 32'h0 : ram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: table vectors, burst, reset mid-burst and random traffic vs a reference memory.
module tb_sram_like_slave;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_like_slave_if bus();
  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  sram_like_slave #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [31:0] mem     [0:(1<<ADDR_W)-1];
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == 4'b0000) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (ram_wen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int stalls = 0;
  int gaps   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] bmask(input logic [1:0] s, input logic [31:0] a);
    case (s)
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  typedef struct {
    logic [31:0] dat;
    int          acc;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk) begin
    sb_t e;
    if (resetn === 1'b1) begin
      if (bus.data_ok) begin
        if (sb.size() == 0) begin
          chk("spurious data_ok", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rdata", bus.rdata, e.dat);
`ifdef SRAM_LIKE_RAND_DELAY_EN
          chk("latency at least 2", 32'(cyc - e.acc >= 2), 32'd1);
`else
          chk("latency", 32'(cyc - e.acc), 32'd2);
`endif
        end
      end else begin
        chk("rdata idle", bus.rdata, 32'h0);
        if (sb.size() > 0 && (cyc - sb[0].acc) >= 2) gaps++;
      end
      chk("outstanding bound", 32'(sb.size() <= DEPTH), 32'd1);
    end
  end

  task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic use_exp, input logic [31:0] exp_dat,
                       input logic [3:0] exp_wen);
    sb_t e;
    logic [3:0] m;
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.size  = s;
    bus.addr  = a;
    bus.wdata = d;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.addr_ok) begin
        chk("ram_wen", {28'h0, ram_wen}, {28'h0, exp_wen});
        chk("ram_addr", {16'h0, ram_addr}, {16'h0, a[ADDR_W+1:2]});
        if (w) chk("ram_wdata", ram_wdata, d);
        e.dat = use_exp ? exp_dat : (w ? 32'h0 : ref_mem[a[ADDR_W+1:2]]);
        e.acc = cyc;
        sb.push_back(e);
        if (w) begin
          m = bmask(s, a);
          for (int b = 0; b < 4; b++) begin
            if (m[b]) ref_mem[a[ADDR_W+1:2]][8*b +: 8] = d[8*b +: 8];
          end
        end
        @(posedge clk);
        #1;
        return;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    chk("addr_ok timeout", 32'd0, 32'd1);
    bus.req = 1'b0;
  endtask

  task automatic go_idle();
    bus.req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) return;
      @(posedge clk);
      #1;
    end
    chk("drain timeout", 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wen;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    logic       rw;
    logic [1:0] rs;
    logic [31:0] ra, rd;

    tbl[0]  = '{1'b0, 2'd2, 32'h40, 32'h0,        4'b0000, 32'h12345678};
    tbl[1]  = '{1'b1, 2'd0, 32'h41, 32'h0000AB00, 4'b0010, 32'h0};
    tbl[2]  = '{1'b0, 2'd2, 32'h40, 32'h0,        4'b0000, 32'h1234AB78};
    tbl[3]  = '{1'b1, 2'd0, 32'h43, 32'hAA000000, 4'b1000, 32'h0};
    tbl[4]  = '{1'b0, 2'd2, 32'h40, 32'h0,        4'b0000, 32'hAA34AB78};
    tbl[5]  = '{1'b1, 2'd1, 32'h41, 32'h0000CDEF, 4'b0011, 32'h0};
    tbl[6]  = '{1'b0, 2'd2, 32'h40, 32'h0,        4'b0000, 32'hAA34CDEF};
    tbl[7]  = '{1'b1, 2'd1, 32'h42, 32'h11220000, 4'b1100, 32'h0};
    tbl[8]  = '{1'b0, 2'd2, 32'h40, 32'h0,        4'b0000, 32'h1122CDEF};
    tbl[9]  = '{1'b1, 2'd2, 32'h47, 32'hDEADBEEF, 4'b1111, 32'h0};
    tbl[10] = '{1'b0, 2'd2, 32'h44, 32'h0,        4'b0000, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 2'd3, 32'h44, 32'h01020304, 4'b1111, 32'h0};
    tbl[12] = '{1'b0, 2'd0, 32'h45, 32'h0,        4'b0000, 32'h01020304};

    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'hC0DE0000 + i;
      ref_mem[i] = 32'hC0DE0000 + i;
    end
    mem[16]     = 32'h12345678;
    ref_mem[16] = 32'h12345678;

    resetn    = 1'b0;
    bus.req   = 1'b1;
    bus.wr    = 1'b1;
    bus.size  = 2'd2;
    bus.addr  = 32'h40;
    bus.wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset addr_ok", {31'h0, bus.addr_ok}, 32'd0);
    chk("reset data_ok", {31'h0, bus.data_ok}, 32'd0);
    chk("reset ram_en", {31'h0, ram_en}, 32'd0);
    chk("reset ram_wen", {28'h0, ram_wen}, 32'd0);
    chk("reset rdata", bus.rdata, 32'h0);
    bus.req = 1'b0;
    resetn  = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].exp_rdata, tbl[i].exp_wen);
      go_idle();
    end
    drain();

    s0 = stalls;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 2'd2, 32'h48 + 32'(4 * i), 32'h0, 1'b1, 32'hC0DE0012 + i, 4'b0000);
    end
    go_idle();
    drain();
`ifndef SRAM_LIKE_RAND_DELAY_EN
    chk("burst addr_ok stalls", 32'(stalls - s0), 32'd0);
`endif

    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 2'd2, 32'h60 + 32'(4 * i), 32'h0, 1'b0, 32'h0, 4'b0000);
    end
    bus.req  = 1'b1;
    bus.wr   = 1'b0;
    bus.addr = 32'h70;
    #2;
    resetn = 1'b0;
    #1;
    chk("mid-burst reset addr_ok", {31'h0, bus.addr_ok}, 32'd0);
    chk("mid-burst reset data_ok", {31'h0, bus.data_ok}, 32'd0);
    chk("mid-burst reset ram_en", {31'h0, ram_en}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("held reset data_ok", {31'h0, bus.data_ok}, 32'd0);
    bus.req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 32'h80, 32'h0, 1'b1, 32'hC0DE0020, 4'b0000);
    go_idle();
    drain();
    repeat (4) go_idle();

    for (int i = 0; i < 1000; i++) begin
      rw = 1'($urandom_range(0, 1));
      rs = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255));
      rd = $urandom;
      issue(rw, rs, ra, rd, 1'b0, 32'h0, rw ? bmask(rs, ra) : 4'b0000);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    drain();

`ifdef SRAM_LIKE_RAND_DELAY_EN
    chk("addr_ok stalls observed", 32'(stalls > 0), 32'd1);
    chk("data_ok gaps observed", 32'(gaps > 0), 32'd1);
`else
    chk("no data_ok gaps", 32'(gaps), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
- Responder end of the sram-like request/response interface that the instruction and data fetch stages drive (req/addr_ok address handshake, data_ok/rdata response).
- Accepts in-order requests and services them from a synchronous single-port RAM with 1-cycle read latency.
- Returns responses strictly in request order, with a bounded number of outstanding transactions.
- Used as the inst/data memory model in the verification top, and as the template for the later AXI bridge slave side.

Parameters:
- ADDR_W, 16, word-address width of the backing RAM (capacity 2^ADDR_W words).
- DEPTH, 4, max outstanding transactions; power of two, 2..16.
- LFSR_SEED, 16'h5a5a, nonzero seed for the delay LFSR (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  master request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- addr  in  32  byte address.
- wdata  in  32  write data, lane-aligned by the master.
- addr_ok  out  1  request accepted this cycle.
- data_ok  out  1  response valid this cycle; the master always consumes it.
- rdata  out  32  read data (0 for write responses).
- ram_en  out  1  RAM access enable.
- ram_wen  out  4  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_wen == 0.

Behaviour:
- Reset (resetn low, asynchronous): outstanding count = 0, response FIFO empty, pipeline-valid = 0, LFSR = LFSR_SEED. All outputs are 0 while reset is held. Any transaction in flight when reset asserts is dropped.
- Request acceptance:
  - addr_ok = req && (cnt < DEPTH) && !blk_a, where cnt = pipe_valid + fifo_count + pending accepted.
  - addr_ok is combinational and depends on req. No request is ever accepted when cnt == DEPTH.
- RAM access: issued in the acceptance cycle T.
  - ram_en = addr_ok.
  - ram_addr = addr[ADDR_W+1:2].
  - ram_wdata = wdata.
  - ram_wen = wr ? mask : 0.
  - mask: size 0 -> 4'b0001 << addr[1:0]; size 1 -> 4'b0011 << {addr[1],1'b0}; size 2/3 -> 4'b1111. addr[0] is ignored for halfword, addr[1:0] is ignored for word.
- Stage 1 (cycle T+1): pipe_valid and pipe_wr are registered at T. At T+1, if pipe_valid, push wr ? 32'h0 : ram_rdata into the response FIFO.
- Response:
  - data_ok = !fifo_empty && !blk_d.
  - rdata = FIFO head; rdata = 0 when data_ok = 0.
  - Pop on data_ok.
  - Minimum latency: accept at T -> data_ok at T+2.
- Count: +1 on addr_ok, -1 on data_ok, unchanged when both occur in the same cycle. The count never exceeds DEPTH and never underflows.
- FIFO: DEPTH entries. Pointers have log2(DEPTH)+1 bits and wrap. A push and a pop in the same cycle on a full FIFO cannot occur, because the count gating prevents it. A push and a pop on a non-empty FIFO keeps occupancy unchanged.
- Ordering: responses are strictly FIFO. A write followed by a read to the same word returns the new data, because the RAM is write-first across cycles.
- blk_a = blk_d = 0 unless the optional feature is enabled.

Optional Feature:
- Macro: SRAM_LIKE_RAND_DELAY_EN.
- With the macro defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - blk_a = (lfsr[1:0] == 2'b00). This gives random addr_ok back-pressure even when slots are free.
  - blk_d = (lfsr[3:2] == 2'b00). This holds data_ok low while the FIFO is non-empty, so response latency becomes T+2 or later.
  - Ordering and count rules are unchanged.
- Without the macro: blk_a = blk_d = 0 and the LFSR is not instantiated. Behaviour is fully deterministic: fixed T+2 latency and back-to-back acceptance up to DEPTH.

Test Plan:
- Preload RAM[0x10] = 32'h12345678; read word addr 0x40 at T -> addr_ok at T, data_ok with rdata 32'h12345678 at T+2.
- Byte write wdata 32'h0000AB00, addr 0x41 -> ram_wen 4'b0010. Then read word 0x40 -> rdata 32'h1234AB78. The write response gives data_ok with rdata 0.
- Hold req high for 8 reads to consecutive words with DEPTH = 4 (no feature) -> addr_ok steady; rdata returned in address order; never more than 4 outstanding.
- Pulse resetn low mid-burst with 3 outstanding -> data_ok, addr_ok and ram_en go 0 immediately. After release, the first new read returns only its own data at T+2, with no stale responses.
- Enable SRAM_LIKE_RAND_DELAY_EN; issue 1000 random reads and writes against a reference memory -> all read data matches, responses stay in order, and addr_ok stalls and data_ok gaps are both observed.
